// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among N_REQ producers
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req, req_data   per-requester request and byte (requester i at [i*DATA_W +: DATA_W])
//   ack             one-cycle pulse to the requester just served
//   tx_data         byte latched for the transmitter at grant time
//   tx_start        one-cycle start pulse to the transmitter
//   tx_busy,tx_done transmitter status (busy level, done pulse)
//   gnt_idx         current or last granted requester
//   active          high from START through ACK
//   to_err, err_clr sticky watchdog error and its synchronous clear
module uart_tx_arbiter #(
  parameter  int N_REQ     = 4,
  parameter  int DATA_W    = 8,
  parameter  int TO_CYCLES = 200000,
  parameter  int TO_W      = 18,
  localparam int IDX_W     = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  input  logic                    tx_done,
  output logic [IDX_W-1:0]        gnt_idx,
  output logic                    active,
  output logic                    to_err,
  input  logic                    err_clr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_ACK
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   ptr;
  logic [TO_W-1:0]    wd_cnt;
  logic [IDX_W-1:0]   win_idx;
  logic               win_vld;
  logic [IDX_W:0]     cand;
  logic [DATA_W-1:0]  win_data;
  logic               waiting;
  logic               wd_expire;

  // Round-robin search: walk offsets from high to low so the requester
  // closest to ptr (lowest offset) is the last write and therefore wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (cand >= (IDX_W + 1)'(N_REQ)) begin
        cand = cand - (IDX_W + 1)'(N_REQ);
      end
      if (req[cand[IDX_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign waiting = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);

  // The counter is 0 in the first wait cycle, so it reaches TO_CYCLES-1 on
  // the same edge that leaves for ACK; a done on that edge still wins.
  assign wd_expire = waiting && !tx_done && (wd_cnt == TO_W'(TO_CYCLES - 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    active    = 1'b0;
    ack       = '0;
    case (state)
      S_IDLE: begin
        if (win_vld) state_nxt = S_START;
      end
      S_START: begin
        tx_start  = 1'b1;
        active    = 1'b1;
        state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        active = 1'b1;
        if (tx_done || wd_expire) state_nxt = S_ACK;
        else if (tx_busy)         state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        active = 1'b1;
        if (tx_done || wd_expire) state_nxt = S_ACK;
      end
      S_ACK: begin
        active    = 1'b1;
        ack       = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_idx <= '0;
      tx_data <= '0;
      ptr     <= '0;
      wd_cnt  <= '0;
      to_err  <= 1'b0;
    end else begin
      if (state == S_IDLE && win_vld) begin
        gnt_idx <= win_idx;
        tx_data <= win_data;
      end
      if (state == S_START) begin
        wd_cnt <= '0;
      end else if (waiting) begin
        wd_cnt <= wd_cnt + TO_W'(1);
      end
      if (state == S_ACK) begin
        ptr <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
      // Set beats clear when both happen on the same edge.
      if (wd_expire) begin
        to_err <= 1'b1;
      end else if (err_clr) begin
        to_err <= 1'b0;
      end
    end
  end

endmodule
